// File: rtl/mem_burst_pkg.sv
// Shared types, default sizing and the parity helper for the burst memory controller.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LAT    = 3;
  localparam int DEF_LEN_W  = 4;
  localparam int PAR_MAX_W  = 64;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Request/stream bus between the control FSM (master) and the burst memory controller (slave).
interface mem_burst_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);

  logic              start;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              done;
  logic              perr;

  modport master (
    output start, wr, address, len, wdata,
    input  wready, rdata, rvalid, busy, done, perr
  );

  modport slave (
    input  start, wr, address, len, wdata,
    output wready, rdata, rvalid, busy, done, perr
  );

endinterface

// File: rtl/sync_ram_sp.sv
// Single-port synchronous RAM with a one-cycle registered read; returns old data on a same-address write.
module sync_ram_sp #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive a controller reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read see the pre-write contents of mem[addr].
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller around a single-port RAM with per-word access latency LAT.
// Define MEM_BURST_PARITY_EN to store an even-parity bit per word and flag mismatches on perr.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LAT    = DEF_LAT,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_burst_ctrl_if.slave bus
);

  if (LAT < 1) begin : g_lat_chk
    $error("mem_burst_ctrl: LAT must be >= 1");
  end

  localparam int            CW    = $clog2(LAT) + 1;
  localparam logic [CW-1:0] WLAST = CW'(LAT - 1);

`ifdef MEM_BURST_PARITY_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              perr_q, perr_d;

  logic              wready;
  logic              ram_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [RW-1:0]     ram_wdata;
  logic [RW-1:0]     ram_rdata;
  logic              par_err;

  assign cur_addr = base_q + ADDR_W'(k_q);
  assign wready   = (state_q == ACCESS) && wr_q && (wcnt_q == '0);
  assign ram_we   = wready && rst_n;

  // Reads present the address of the upcoming ACCESS cycle so RAM data is ready at every wait count,
  // which keeps LAT=1 working with the registered RAM read.
  assign ram_addr = ((state_q == ACCESS) && wr_q) ? cur_addr : base_d + ADDR_W'(k_d);

`ifdef MEM_BURST_PARITY_EN
  assign ram_wdata = {even_parity(PAR_MAX_W'(bus.wdata)), bus.wdata};
  assign par_err   = (ram_rdata[DATA_W] != even_parity(PAR_MAX_W'(ram_rdata[DATA_W-1:0])))
                     || $isunknown(ram_rdata[DATA_W]);
`else
  assign ram_wdata = bus.wdata;
  assign par_err   = 1'b0;
`endif

  sync_ram_sp #(
    .WIDTH (RW),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every target gets a default first, so no path through the case infers a latch.
    state_d  = state_q;
    wr_d     = wr_q;
    base_d   = base_q;
    len_d    = len_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    perr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          wr_d    = bus.wr;
          base_d  = bus.address;
          len_d   = bus.len;
          k_d     = '0;
          wcnt_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wcnt_q == WLAST) begin
          if (!wr_q) begin
            rdata_d  = ram_rdata[DATA_W-1:0];
            rvalid_d = 1'b1;
            perr_d   = par_err;
          end
          wcnt_d = '0;
          if (k_q == len_q) begin
            state_d = DONE;
          end else begin
            k_d = k_q + LEN_W'(1);
          end
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      wcnt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.wready = wready;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.perr   = perr_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: a word-array memory model predicts every pulse and read word.
module tb_mem_burst_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LAT    = 3;
  localparam int LEN_W  = 4;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        perr;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  logic [15:0] model   [256];
  logic        corrupt [256];
  logic [15:0] wbuf    [16];

  int      exp_wr[$];
  int      exp_done[$];
  rd_exp_t exp_rd[$];

  mem_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mem_burst_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LAT    (LAT),
    .LEN_W  (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    int      e;
    rd_exp_t r;
    if (rst_n) begin
      check("busy", bus.busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (bus.wready) begin
        if (exp_wr.size() == 0) check("wready_unexpected", bus.wready, 0);
        else begin
          e = exp_wr.pop_front();
          check("wready_cycle", cyc, e);
        end
      end
      if (bus.rvalid) begin
        if (exp_rd.size() == 0) check("rvalid_unexpected", bus.rvalid, 0);
        else begin
          r = exp_rd.pop_front();
          check("rvalid_cycle", cyc, r.cyc);
          check("rdata", bus.rdata, r.data);
          check("perr", bus.perr, r.perr);
        end
      end else if (bus.perr) begin
        check("perr_without_rvalid", bus.perr, 0);
      end
      if (bus.done) begin
        if (exp_done.size() == 0) check("done_unexpected", bus.done, 0);
        else begin
          e = exp_done.pop_front();
          check("done_cycle", cyc, e);
        end
      end
    end
  end

  // Issues one burst using wbuf as write data. ign_at > 0 pulses an extra start that many cycles in;
  // rst_at > 0 asserts reset in that cycle of the burst.
  task automatic run_burst(input logic w, input logic [7:0] a, input logic [3:0] l,
                           input int ign_at, input int rst_at);
    int          c0, n, last_t, word;
    logic [7:0]  wa;
    rd_exp_t     r;
    @(negedge clk);
    c0          = cyc;
    n           = int'(l) + 1;
    bus.start   = 1'b1;
    bus.wr      = w;
    bus.address = a;
    bus.len     = l;
    bus.wdata   = wbuf[0];
    last_t      = (rst_at > 0) ? rst_at - 1 : n * LAT + 1;
    busy_lo     = c0 + 1;
    busy_hi     = c0 + last_t;
    for (int i = 0; i < n; i++) begin
      wa = a + 8'(i);
      if (w) begin
        if (rst_at <= 0 || (1 + i * LAT) < rst_at) begin
          exp_wr.push_back(c0 + 1 + i * LAT);
          model[wa]   = wbuf[i];
          corrupt[wa] = 1'b0;
        end
      end else if (rst_at <= 0) begin
        r.cyc  = c0 + (i + 1) * LAT + 1;
        r.data = model[wa];
        r.perr = corrupt[wa];
        exp_rd.push_back(r);
      end
    end
    if (rst_at <= 0) exp_done.push_back(c0 + n * LAT + 1);

    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      bus.start = (t == ign_at);
      if (t == ign_at) begin
        bus.wr      = 1'b1;
        bus.address = a ^ 8'h80;
        bus.len     = 4'($urandom);
      end
      word      = (t - 1) / LAT;
      bus.wdata = wbuf[(word < n) ? word : 0];
    end

    if (rst_at > 0) begin
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_wready", bus.wready, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_rdata", bus.rdata, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      bus.start = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.wr      = 1'b0;
    bus.address = '0;
    bus.len     = '0;
    bus.wdata   = '0;
    for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_wready", bus.wready, 0);
    check("reset_rvalid", bus.rvalid, 0);
    check("reset_perr", bus.perr, 0);
    check("reset_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole RAM so every later read has a known expectation.
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
      run_burst(1'b1, 8'(b * 16), 4'd15, 0, 0);
    end

    // Single write then single read.
    wbuf[0] = 16'hBEEF;
    run_burst(1'b1, 8'h10, 4'd0, 0, 0);
    run_burst(1'b0, 8'h10, 4'd0, 0, 0);

    // Four-word burst write then burst read.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
    run_burst(1'b1, 8'h20, 4'd3, 0, 0);
    run_burst(1'b0, 8'h20, 4'd3, 0, 0);

    // Wrap-around from the top address.
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'h5555;
    run_burst(1'b1, 8'hFF, 4'd1, 0, 0);
    run_burst(1'b0, 8'hFF, 4'd0, 0, 0);
    run_burst(1'b0, 8'h00, 4'd0, 0, 0);
    run_burst(1'b0, 8'hFF, 4'd1, 0, 0);

    // Start during busy is ignored; its target (0x40 ^ 0x80) must be untouched.
    run_burst(1'b0, 8'h40, 4'd2, 2, 0);
    run_burst(1'b0, 8'hC0, 4'd0, 0, 0);

    // Reset in cycle 5 of a four-word write keeps words 0 and 1 only.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h1111 * 16'(i + 1);
    run_burst(1'b1, 8'h60, 4'd3, 0, 5);
    run_burst(1'b0, 8'h60, 4'd3, 0, 0);

`ifdef MEM_BURST_PARITY_EN
    wbuf[0] = 16'h1234;
    run_burst(1'b1, 8'h30, 4'd0, 0, 0);
    @(negedge clk);
    dut.u_ram.mem[8'h30][0] = ~dut.u_ram.mem[8'h30][0];
    model[8'h30][0]         = ~model[8'h30][0];
    corrupt[8'h30]          = 1'b1;
    run_burst(1'b0, 8'h30, 4'd0, 0, 0);
    run_burst(1'b0, 8'h31, 4'd0, 0, 0);
`endif

    // Randomised mix with idle gaps and occasional ignored starts.
    for (int it = 0; it < 60; it++) begin
      logic [3:0] l;
      int         ign;
      l = 4'($urandom);
      for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
      ign = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (int'(l) + 1) * LAT + 1) : 0;
      idle($urandom_range(0, 2));
      run_burst(1'($urandom), 8'($urandom), l, ign, 0);
    end

    idle(8);
    check("wready_left", exp_wr.size(), 0);
    check("rvalid_left", exp_rd.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Parametrised successor to the single-word memory access wrapper. Owns a single-port synchronous RAM and runs single-word or burst reads/writes behind a start/done handshake, with a configurable per-word access latency. Sits between the coprocessor control FSM and on-chip matrix storage. Adds a streaming write/read data interface, address wrap-around, a busy flag and optional parity checking.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
LAT, 3, cycles each word occupies in ACCESS; must be >= 1, and LAT < 1 is an elaboration error
LEN_W, 4, width of burst length field; max burst is 2**LEN_W words

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request strobe; sampled only when busy=0
wr  in  1  1=write burst, 0=read burst; latched with start
address  in  ADDR_W  base word address; latched with start
len  in  LEN_W  burst length minus one (0 means 1 word)
wdata  in  DATA_W  write word; sampled only in cycles with wready=1
wready  out  1  one-cycle pulse: wdata is consumed this cycle
rdata  out  DATA_W  read word; valid when rvalid=1, held otherwise
rvalid  out  1  one-cycle pulse per read word
busy  out  1  high from the cycle after start is accepted through the done cycle inclusive
done  out  1  one-cycle completion pulse
perr  out  1  parity error flag, pulses with rvalid (see Optional Feature)

Behaviour:
- Reset: state=IDLE; wready, rvalid, busy, done and perr = 0; rdata = 0; counters = 0. RAM contents are not cleared. A RAM write at an edge where rst_n=0 is suppressed.
- Reset mid-burst: abort immediately. No done pulse. Words already written stay written.
- States:
  - IDLE: start=1 latches wr, address, len; word index k=0; go to ACCESS.
  - ACCESS: presents RAM address (base+k) mod DEPTH; wait counter runs 0..LAT-1.
  - DONE: one cycle with done=1, then IDLE.
- Each word occupies exactly LAT ACCESS cycles.
- Write word:
  - wready=1 and RAM we=1 on wait count 0; wdata goes straight to RAM.
  - The master must drive valid wdata whenever wready=1. There is no back-pressure.
- Read word:
  - rdata is registered from RAM output at wait count LAT-1.
  - rvalid=1 in the following cycle: the first ACCESS cycle of word k+1, or the DONE cycle for the last word.
- After wait count LAT-1: if k==len go to DONE, else k+1 and restart the wait counter.
- Latency, start accepted at cycle 0:
  - ACCESS spans cycles 1..(len+1)*LAT.
  - done at cycle (len+1)*LAT+1.
  - Single read with LAT=3: rvalid and done both at cycle 4.
- start while busy=1 is ignored; it is neither queued nor an error. The next start can be accepted in the cycle after done.
- Wrap: addresses increment modulo DEPTH. A burst from DEPTH-1 continues at 0.
- Arithmetic: k and the wait counter are unsigned. k is LEN_W bits; the wait counter is clog2(LAT)+1 bits.

Optional Feature:
MEM_BURST_PARITY_EN
- Defined:
  - RAM is DATA_W+1 wide; writes store the even parity of wdata.
  - On each read, stored parity is compared with recomputed parity; perr=1 in the rvalid cycle on mismatch.
  - perr is also forced high whenever rvalid=1 and the RAM parity bit is X in simulation.
- Undefined: RAM is DATA_W wide and perr is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package mem_burst_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - default width/latency constants
  - parity function
- Sub-module sync_ram_sp:
  - single-port RAM, parameters WIDTH and AW
  - one-cycle registered read
  - read-old-data on same-address write
  - inferable, no reset of the array

Test Plan:
- Single write then read, LAT=3: write 0xBEEF at address 0x10 (len=0), then read 0x10 -> wready at cycle 1, done at cycle 4; read gives rvalid and done at cycle 4 with rdata=0xBEEF.
- Burst write len=3 at 0x20 with 0x0001..0x0004, then burst read -> four rvalid pulses spaced 3 cycles apart with data 0x0001..0x0004; done at cycle 13.
- Wrap: burst write len=1 at 0xFF with 0xAAAA, 0x5555 -> read of 0xFF gives 0xAAAA and read of 0x00 gives 0x5555.
- start pulsed during busy (cycle 2 of a burst) -> ignored: one done pulse only, RAM unchanged at the second request's address.
- rst_n low at cycle 5 of a len=3 write -> outputs 0 immediately, no done; words 0 and 1 retained, words 2 and 3 unchanged.
- MEM_BURST_PARITY_EN: force-flip a stored data bit at 0x30, then read -> perr=1 coincident with rvalid; a clean word gives perr=0.
